// File: rtl/sm_add_pkg.sv
// Shared types and arithmetic for the sign-magnitude adder arbiter.
// sm5_t carries a 4-bit magnitude operand; sm6_t carries the 5-bit magnitude sum.
package sm_add_pkg;

  localparam int SM5_SIGN_BIT = 4;
  localparam int SM5_MAG_W    = 4;
  localparam int SM5_W        = SM5_SIGN_BIT + 1;
  localparam int SM6_SIGN_BIT = 5;
  localparam int SM6_MAG_W    = 5;
  localparam int SM6_W        = SM6_SIGN_BIT + 1;

  typedef struct packed {
    logic                 sign;
    logic [SM5_MAG_W-1:0] mag;
  } sm5_t;

  typedef struct packed {
    logic                 sign;
    logic [SM6_MAG_W-1:0] mag;
  } sm6_t;

  // Negative zero is folded to +0 before the sign comparison, and a zero
  // result always carries sign 0.
  function automatic sm6_t sm_add(input sm5_t a, input sm5_t b);
    sm6_t r;
    logic sa;
    logic sb;
    sa = a.sign & (a.mag != '0);
    sb = b.sign & (b.mag != '0);
    r  = '0;
    if (sa == sb) begin
      r.mag  = {1'b0, a.mag} + {1'b0, b.mag};
      r.sign = sa;
    end else if (a.mag >= b.mag) begin
      r.mag  = {1'b0, a.mag - b.mag};
      r.sign = sa;
    end else begin
      r.mag  = {1'b0, b.mag - a.mag};
      r.sign = sb;
    end
    if (r.mag == '0) begin
      r.sign = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/sm_add_arbiter_if.sv
// Requester and response bundle of the shared adder; the arbiter sits on the
// slave side, the requesters and the result consumer on the master side.
interface sm_add_arbiter_if import sm_add_pkg::*; #(
  parameter int NREQ = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0][SM5_W-1:0] req_a;
  logic [NREQ-1:0][SM5_W-1:0] req_b;
  logic [NREQ-1:0]            req_ready;
  logic                       rsp_valid;
  logic [SM6_W-1:0]           rsp_data;
  logic [IDW-1:0]             rsp_id;
  logic                       rsp_ready;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/sm_add_core.sv
// Two-stage sign-magnitude adder: stage 1 registers the operands and id,
// stage 2 is the combinational sum consumed by the output buffer.
module sm_add_core import sm_add_pkg::*; #(
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid_i,
  input  sm5_t           in_a_i,
  input  sm5_t           in_b_i,
  input  logic [IDW-1:0] in_id_i,
  output logic           out_valid_o,
  output sm6_t           out_sum_o,
  output logic [IDW-1:0] out_id_o
);

  logic           valid_q;
  sm5_t           a_q;
  sm5_t           b_q;
  logic [IDW-1:0] id_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= '0;
    end else begin
      valid_q <= in_valid_i;
      if (in_valid_i) begin
        a_q  <= in_a_i;
        b_q  <= in_b_i;
        id_q <= in_id_i;
      end
    end
  end

  assign out_valid_o = valid_q;
  assign out_sum_o   = sm_add(a_q, b_q);
  assign out_id_o    = id_q;

endmodule

// File: rtl/sm_add_arbiter.sv
// Round-robin arbiter sharing one pipelined sign-magnitude adder among NREQ
// requesters, with a credit-protected in-order result FIFO.
module sm_add_arbiter import sm_add_pkg::*; #(
  parameter int NREQ      = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  sm_add_arbiter_if.slave  bus
);

  localparam int IDW = $clog2(NREQ);
  localparam int AW  = $clog2(OUT_DEPTH);
  localparam int CW  = AW + 2;

  typedef struct packed {
    logic [IDW-1:0] id;
    sm6_t           sum;
  } entry_t;

  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  ptr_d;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic            grant_any;
  logic [IDW:0]    idx;
  logic            credit_ok;
  logic            accept;
  sm5_t            sel_a;
  sm5_t            sel_b;

  logic            s1_valid;
  sm6_t            s2_sum;
  logic [IDW-1:0]  s2_id;

  logic [AW:0]     wr_ptr_q;
  logic [AW:0]     rd_ptr_q;
  logic [AW:0]     occ;
  logic [CW-1:0]   cnt;
  logic            fifo_nonempty;
  logic            push;
  logic            pop;
  entry_t          mem_q [OUT_DEPTH];
  entry_t          head;

  // First valid requester at or after ptr, wrapping around.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    idx       = '0;
    for (int off = 0; off < NREQ; off++) begin
      idx = (IDW+1)'(ptr_q) + (IDW+1)'(off);
      if (idx >= (IDW+1)'(NREQ)) begin
        idx = idx - (IDW+1)'(NREQ);
      end
      if (!grant_any && bus.req_valid[idx[IDW-1:0]]) begin
        grant_any               = 1'b1;
        grant_id                = idx[IDW-1:0];
        grant[idx[IDW-1:0]]     = 1'b1;
      end
    end
  end

  // Credits count results already buffered plus the one in stage 1.
  assign occ       = wr_ptr_q - rd_ptr_q;
  assign cnt       = CW'(occ) + CW'(s1_valid);
  assign credit_ok = (cnt < CW'(OUT_DEPTH));
  assign accept    = grant_any & credit_ok & ~rst;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
      assign bus.req_ready[gi] = grant[gi] & credit_ok & ~rst;
    end
  endgenerate

  assign sel_a = sm5_t'(bus.req_a[grant_id]);
  assign sel_b = sm5_t'(bus.req_b[grant_id]);

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  sm_add_core #(.IDW(IDW)) u_core (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (accept),
    .in_a_i      (sel_a),
    .in_b_i      (sel_b),
    .in_id_i     (grant_id),
    .out_valid_o (s1_valid),
    .out_sum_o   (s2_sum),
    .out_id_o    (s2_id)
  );

  assign fifo_nonempty = (occ != '0);
  assign push          = s1_valid;
  assign pop           = fifo_nonempty & bus.rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= '{id: s2_id, sum: s2_sum};
    end
  end

  // Outputs read as zero whenever the buffer is empty, including after reset.
  assign head          = mem_q[rd_ptr_q[AW-1:0]];
  assign bus.rsp_valid = fifo_nonempty;
  assign bus.rsp_data  = fifo_nonempty ? head.sum : '0;
  assign bus.rsp_id    = fifo_nonempty ? head.id : '0;

endmodule
